rr_decode_arbiter: RTL and testbench
====================================

RR_DECODE_ARBITER -- requirements
Module: rr_decode_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, default 8, legal 2..16; the maximum number of consecutive grant cycles an owner keeps while another requester waits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req  input  4  request lines; req[i] high means requester i wants the shared resource.
REQ-005 grant_idx  output  2  index of the current or most recent owner; drives the 2-to-4 decoder select input.
REQ-006 grant_en  output  1  grant valid; drives the decoder enable input.
REQ-007 grant  output  4  one-hot grant, equal to (1 << grant_idx) when grant_en=1, else 4'b0000.
REQ-008 busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-009 All outputs SHALL be registered, except grant, which SHALL be decoded combinationally from registered grant_idx and grant_en.
REQ-010 FSM states: IDLE, GRANT, GAP.
REQ-011 Priority pointer ptr (2 bits) SHALL select the winner as the first i with req[i]=1, searching ptr, ptr+1, ptr+2, ptr+3, all mod 4.
REQ-012 IDLE: grant_en=0; if any req bit is 1 at a clock edge, the next state is GRANT, grant_idx=winner, grant_en=1, and hold_cnt=0.
REQ-013 Latency: a request sampled at edge N with the FSM in IDLE SHALL produce grant_en=1 after edge N (one cycle).
REQ-014 GRANT: hold_cnt SHALL increment each cycle and saturate at MAX_HOLD-1.
REQ-015 GRANT exits to GAP when req[grant_idx]=0 is sampled.
REQ-016 GRANT also exits to GAP when hold_cnt==MAX_HOLD-1 and any other req bit is 1.
REQ-017 GRANT with hold_cnt saturated and no other request SHALL remain in GRANT (no forced release).
REQ-018 On the GRANT->GAP transition, ptr SHALL be set to (grant_idx+1) mod 4.
REQ-019 GAP: grant_en=0 for exactly one cycle (turnaround), and grant_idx SHALL keep the previous owner.
REQ-020 GAP next state: GRANT with the new winner chosen per REQ-011 using the updated ptr if any req bit is 1, else IDLE.
REQ-021 Ownership SHALL never change without an intervening GAP cycle; two different grant bits SHALL never be high in the same or adjacent cycles.
REQ-022 Requests arriving during GRANT or GAP SHALL be evaluated only at arbitration points (IDLE or GAP edge); nothing is latched or queued.
REQ-023 A requester that drops and reasserts req during GAP is eligible like any other requester, subject to ptr.

Reset
REQ-024 On rst_n=0, asynchronously: state=IDLE, grant_en=0, grant=0000, grant_idx=00, ptr=00, hold_cnt=0, busy=0.
REQ-025 Reset asserted mid-GRANT SHALL drop grant immediately, without waiting for a clock edge.
REQ-026 After rst_n deasserts, arbitration SHALL resume at the first rising edge with ptr=0.

Verification
REQ-027 After reset, req=0110 held -> one cycle later grant_idx=1, grant=0010, busy=1.
REQ-028 Owner 1 drops req; req=0100 -> one GAP cycle with grant=0000, then grant=0100 (idx 2).
REQ-029 MAX_HOLD=8; req=0011 held continuously -> owner 0 for 8 cycles, 1 GAP cycle, owner 1 for 8 cycles, 1 GAP cycle, owner 0 again.
REQ-030 req=0001 held 20 cycles alone -> grant=0001 for all 20 cycles, with no GAP cycle.
REQ-031 req=1111 held with MAX_HOLD=2 -> grant sequence 0001, 0001, 0000, 0010, 0010, 0000, 0100, ... in fair rotation.
REQ-032 rst_n pulled low mid-GRANT, between clock edges -> grant=0000 and busy=0 immediately; the first grant after release goes to the lowest-index active requester.

Source files
------------

// File: rtl/rr_decode_arbiter.sv
// rr_decode_arbiter
//   Round-robin arbiter for four requesters. It drives the select and enable
//   inputs of a 2-to-4 decoder. Each change of owner passes through one
//   turnaround (GAP) cycle. While another requester waits, an owner keeps the
//   grant for at most MAX_HOLD consecutive cycles.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[3:0]   request lines, one per requester
//   grant_idx  current or most recent owner (decoder select), registered
//   grant_en   grant valid (decoder enable), registered
//   grant[3:0] one-hot grant decoded from grant_idx/grant_en
//   busy       FSM not IDLE, registered
module rr_decode_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [1:0] grant_idx,
    output logic       grant_en,
    output logic [3:0] grant,
    output logic       busy
);

    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [1:0]    grant_idx_q, grant_idx_d;
    logic          grant_en_q, grant_en_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          busy_q, busy_d;

    logic [1:0] winner;
    logic       any_req;
    logic       other_req;

    // First requester found when searching from ptr upward, modulo 4.
    // The loop runs from the farthest offset down, so the nearest hit wins.
    always_comb begin
        logic [1:0] cand;
        winner = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (req[cand]) winner = cand;
        end
    end

    assign any_req   = |req;
    assign other_req = |(req & ~(4'b0001 << grant_idx_q));

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        grant_en_d  = grant_en_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        unique case (state_q)
            S_IDLE, S_GAP: begin
                // Arbitration point. Requests are only evaluated here.
                if (any_req) begin
                    state_d     = S_GRANT;
                    grant_idx_d = winner;
                    grant_en_d  = 1'b1;
                    hold_cnt_d  = '0;
                end else begin
                    state_d    = S_IDLE;
                    grant_en_d = 1'b0;
                end
            end
            S_GRANT: begin
                if (!req[grant_idx_q] || (hold_cnt_q == HOLD_LAST && other_req)) begin
                    // grant_idx keeps the old owner through the GAP cycle.
                    state_d    = S_GAP;
                    grant_en_d = 1'b0;
                    ptr_d      = grant_idx_q + 2'd1;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                grant_en_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_idx_q <= 2'd0;
            grant_en_q  <= 1'b0;
            ptr_q       <= 2'd0;
            hold_cnt_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            grant_en_q  <= grant_en_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign grant_idx = grant_idx_q;
    assign grant_en  = grant_en_q;
    assign busy      = busy_q;
    assign grant     = grant_en_q ? (4'b0001 << grant_idx_q) : 4'b0000;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
module tb_rr_decode_arbiter;

    logic       clk = 1'b0;
    logic       rst8_n, rst2_n;
    logic [3:0] req8, req2;
    logic [1:0] idx8, idx2;
    logic       en8, en2, busy8, busy2;
    logic [3:0] grant8, grant2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rr_decode_arbiter #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .rst_n(rst8_n), .req(req8),
        .grant_idx(idx8), .grant_en(en8), .grant(grant8), .busy(busy8)
    );

    rr_decode_arbiter #(.MAX_HOLD(2)) dut2 (
        .clk(clk), .rst_n(rst2_n), .req(req2),
        .grant_idx(idx2), .grant_en(en2), .grant(grant2), .busy(busy2)
    );

    task automatic reset8();
        req8 = 4'b0000;
        rst8_n = 1'b0;
        @(negedge clk);
        rst8_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst8_n = 1'b0; rst2_n = 1'b0;
        req8 = 4'b0000; req2 = 4'b0000;
        #2;
        total++;
        if (grant8 !== 4'b0000 || en8 !== 1'b0 || idx8 !== 2'd0 || busy8 !== 1'b0) begin
            bad++;
            $display("FAIL reset8: grant=%b en=%b idx=%0d busy=%b required 0000/0/0/0", grant8, en8, idx8, busy8);
        end
        total++;
        if (grant2 !== 4'b0000 || en2 !== 1'b0 || busy2 !== 1'b0) begin
            bad++;
            $display("FAIL reset2: grant=%b en=%b busy=%b required 0000/0/0", grant2, en2, busy2);
        end
        @(negedge clk);
        rst8_n = 1'b1; rst2_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        req8 = 4'b0110;
        @(negedge clk);
        total++;
        if (idx8 !== 2'd1 || grant8 !== 4'b0010 || busy8 !== 1'b1 || en8 !== 1'b1) begin
            bad++;
            $display("FAIL first_grant: idx=%0d grant=%b busy=%b en=%b required 1/0010/1/1", idx8, grant8, busy8, en8);
        end
        req8 = 4'b0100;
        @(negedge clk);
        total++;
        if (grant8 !== 4'b0000 || idx8 !== 2'd1 || busy8 !== 1'b1) begin
            bad++;
            $display("FAIL gap_cycle: grant=%b idx=%0d busy=%b required 0000/1/1", grant8, idx8, busy8);
        end
        @(negedge clk);
        total++;
        if (grant8 !== 4'b0100 || idx8 !== 2'd2) begin
            bad++;
            $display("FAIL handoff: grant=%b idx=%0d required 0100/2", grant8, idx8);
        end
        req8 = 4'b0000;
        @(negedge clk);
        total++;
        if (grant8 !== 4'b0000 || busy8 !== 1'b1 || idx8 !== 2'd2) begin
            bad++;
            $display("FAIL release_gap: grant=%b busy=%b idx=%0d required 0000/1/2", grant8, busy8, idx8);
        end
        @(negedge clk);
        total++;
        if (busy8 !== 1'b0 || grant8 !== 4'b0000) begin
            bad++;
            $display("FAIL back_to_idle: busy=%b grant=%b required 0/0000", busy8, grant8);
        end
    endtask

    task automatic test_hold_limit();
        logic [3:0] exp;
        reset8();
        req8 = 4'b0011;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            if (i < 8)        exp = 4'b0001;
            else if (i == 8)  exp = 4'b0000;
            else if (i < 17)  exp = 4'b0010;
            else if (i == 17) exp = 4'b0000;
            else              exp = 4'b0001;
            total++;
            if (grant8 !== exp) begin
                bad++;
                $display("FAIL hold_limit cycle %0d: grant=%b required %b", i, grant8, exp);
            end
        end
        req8 = 4'b0000;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_solo_no_release();
        reset8();
        req8 = 4'b0001;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            total++;
            if (grant8 !== 4'b0001) begin
                bad++;
                $display("FAIL solo cycle %0d: grant=%b required 0001", i, grant8);
            end
        end
        req8 = 4'b0000;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_rotation();
        logic [3:0] exp;
        logic [3:0] one;
        one = 4'b0001;
        req2 = 4'b1111;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            exp = (i % 3 == 2) ? 4'b0000 : (one << ((i / 3) % 4));
            total++;
            if (grant2 !== exp) begin
                bad++;
                $display("FAIL rotation cycle %0d: grant=%b required %b", i, grant2, exp);
            end
        end
        req2 = 4'b0000;
    endtask

    task automatic test_async_reset();
        reset8();
        req8 = 4'b1100;
        @(negedge clk);
        req8 = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (grant8 !== 4'b1000) begin
            bad++;
            $display("FAIL pre_reset_owner: grant=%b required 1000", grant8);
        end
        req8 = 4'b1100;
        #2;
        rst8_n = 1'b0;
        #1;
        total++;
        if (grant8 !== 4'b0000 || busy8 !== 1'b0 || en8 !== 1'b0 || idx8 !== 2'd0) begin
            bad++;
            $display("FAIL async_reset: grant=%b busy=%b en=%b idx=%0d required 0000/0/0/0", grant8, busy8, en8, idx8);
        end
        @(negedge clk);
        rst8_n = 1'b1;
        @(negedge clk);
        total++;
        if (grant8 !== 4'b0100 || idx8 !== 2'd2) begin
            bad++;
            $display("FAIL post_reset_grant: grant=%b idx=%0d required 0100/2", grant8, idx8);
        end
        req8 = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_limit();
        test_solo_no_release();
        test_rotation();
        test_async_reset();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
